axis_sum_sink: RTL and testbench

AXIS_SUM_SINK -- requirements
Module: axis_sum_sink

---
 rtl/axis_sum_pkg.sv | 33 +++
 rtl/axis_skid_buffer.sv | 70 +++++++
 rtl/axis_sum_sink.sv | 142 ++++++++++++++
 tb/tb_axis_sum_sink.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sum_pkg.sv
// Shared types and constants for the AXI-Stream packet summing sink.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, result/counter widths, and the sum adder
// helper. The helper can optionally clamp the sum at all-ones.
package axis_sum_pkg;

    localparam int RESULT_W = 32;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Add two unsigned sums. When sat is set, a carry out clamps the result
    // to all-ones. Otherwise the carry is dropped and the sum wraps.
    function automatic logic [RESULT_W-1:0] sum_add(
        input logic [RESULT_W-1:0] a,
        input logic [RESULT_W-1:0] b,
        input logic                sat
    );
        logic [RESULT_W:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (sat && wide[RESULT_W]) begin
            return '1;
        end
        return wide[RESULT_W-1:0];
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid FIFO. The head is presented directly from a register.
// Latency: 1 cycle from push to head valid.
// Backpressure: in_rdy is registered and equals "not full". It is held low during reset.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_dat/vld/rdy   write side (valid/ready)
//   out_dat/vld/rdy  read side; out_rdy acts as the pop strobe when out_vld is high
module axis_skid_buffer
    import axis_sum_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy
);

    logic [W-1:0] mem0;     // head entry
    logic [W-1:0] mem1;     // second entry
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         push;
    logic         pop;

    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;
    assign out_vld = (cnt != 2'd0);
    assign out_dat = mem0;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + 2'd1;
        end else if (pop && !push) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    // Deriving ready from the next occupancy keeps in_rdy registered.
    // It still never lets a push land in a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 2'd0;
            in_rdy <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            in_rdy <= (cnt_nxt != 2'd2);
        end
    end

    // Shift-on-pop storage. A push goes to the first free slot after the pop
    // has been applied. A push while full cannot occur because in_rdy is low.
    always_ff @(posedge clk) begin
        if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
            mem0 <= in_dat;
        end else if (pop) begin
            mem0 <= mem1;
        end
        if (push && cnt == 2'd1 && !pop) begin
            mem1 <= in_dat;
        end
    end

endmodule

// File: rtl/axis_sum_sink.sv
// Sums the beats of each AXI-Stream packet and reports the sum once per packet.
// Latency: result_valid is asserted 2 cycles after the last-beat handshake when nothing is queued ahead of it.
// Backpressure: s_axis_tready is registered and drops when the 2-entry skid buffer is full. stall_i freezes consumption.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast  input stream
//   stall_i                       holds consumption when high
//   result, result_valid          last packet sum, plus a one-cycle update pulse
//   pkt_count                     completed packets, wraps at 16 bits
//   err_len                       sticky flag for a packet longer than MAX_BEATS
// Build option: define AXIS_SUM_SAT_EN to saturate the sum at all-ones instead of wrapping.
module axis_sum_sink
    import axis_sum_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic                stall_i,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid,
    output logic [CNT_W-1:0]    pkt_count,
    output logic                err_len
);

`ifdef AXIS_SUM_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    // The beat counter holds values up to MAX_BEATS+1, where it saturates.
    localparam int               BCNT_W   = $clog2(MAX_BEATS + 2);
    localparam logic [BCNT_W-1:0] BCNT_LIM = BCNT_W'(MAX_BEATS);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BEATS + 1);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W:0]     head_dat;      // {last, data}
    logic                head_vld;
    logic                head_last;
    logic                pop;
    logic [RESULT_W-1:0] data_ext;
    logic [RESULT_W-1:0] sum;
    logic [RESULT_W-1:0] sum_nxt;
    logic [BCNT_W-1:0]   bcnt;
    logic [BCNT_W-1:0]   bcnt_nxt;
    logic                done_ld;

    axis_skid_buffer #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_dat  ({s_axis_tlast, s_axis_tdata}),
        .in_vld  (s_axis_tvalid),
        .in_rdy  (s_axis_tready),
        .out_dat (head_dat),
        .out_vld (head_vld),
        .out_rdy (pop)
    );

    assign head_last = head_dat[DATA_W];

    always_comb begin
        data_ext             = '0;
        data_ext[DATA_W-1:0] = head_dat[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE never pops. That one-cycle gap isolates the reported packet
    // from the first beat of the next packet.
    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        bcnt_nxt  = bcnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (head_vld && !stall_i) begin
                    pop       = 1'b1;
                    sum_nxt   = data_ext;
                    bcnt_nxt  = BCNT_W'(1);
                    state_nxt = head_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (head_vld && !stall_i) begin
                    pop      = 1'b1;
                    sum_nxt  = sum_add(sum, data_ext, SAT_EN);
                    bcnt_nxt = (bcnt == BCNT_MAX) ? bcnt : bcnt + BCNT_W'(1);
                    if (head_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign done_ld      = (state != DONE) && (state_nxt == DONE);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            bcnt      <= '0;
            result    <= '0;
            pkt_count <= '0;
            err_len   <= 1'b0;
        end else begin
            sum  <= sum_nxt;
            bcnt <= bcnt_nxt;
            if (done_ld) begin
                result    <= sum_nxt;
                pkt_count <= pkt_count + CNT_W'(1);
            end
            if (pop && (bcnt_nxt > BCNT_LIM)) begin
                err_len <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_sum_sink.sv
// Self-checking bench for axis_sum_sink.
// Uses a packet table, hand-written corner sequences, and randomized traffic with stalls.
// A packet-level reference model (sum, count, length flag) checks every result pulse.
module tb_axis_sum_sink;

    localparam int MAXB = 16;

    logic        clk;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        stall_i;
    logic [31:0] result;
    logic        result_valid;
    logic [15:0] pkt_count;
    logic        err_len;

    axis_sum_sink #(
        .DATA_W    (32),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .stall_i       (stall_i),
        .result        (result),
        .result_valid  (result_valid),
        .pkt_count     (pkt_count),
        .err_len       (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    typedef struct {
        logic [31:0] sum;
        logic        err;
    } exp_t;

    exp_t        mdl_q[$];
    logic [63:0] cur_sum   = 0;
    int          cur_beats = 0;
    logic        mdl_err   = 0;
    int          mdl_pkts  = 0;
    logic [31:0] last_res  = 0;
    int          acc_cnt   = 0;

    function automatic logic [31:0] fold(input logic [63:0] s);
`ifdef AXIS_SUM_SAT_EN
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
        return s[31:0];
`endif
    endfunction

    // Sampled mid-cycle. The handshake seen here is accepted at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cur_sum   = 0;
            cur_beats = 0;
            mdl_q.delete();
            mdl_err   = 0;
            mdl_pkts  = 0;
            last_res  = 0;
        end else begin
            if (result_valid) begin
                if (mdl_q.size() == 0) begin
                    chk("mon_unexpected_pulse", 1, 0);
                end else begin
                    e = mdl_q.pop_front();
                    mdl_pkts++;
                    chk("mon_result", result, e.sum);
                    chk("mon_err_len", err_len, e.err);
                    chk("mon_pkt_count", pkt_count, 16'(mdl_pkts));
                end
                last_res = result;
            end else begin
                chk("mon_result_hold", result, last_res);
            end
            if (s_axis_tvalid && s_axis_tready) begin
                acc_cnt++;
                cur_sum = cur_sum + s_axis_tdata;
                cur_beats++;
                if (s_axis_tlast) begin
                    if (cur_beats > MAXB) mdl_err = 1'b1;
                    e.sum = fold(cur_sum);
                    e.err = mdl_err;
                    mdl_q.push_back(e);
                    cur_sum   = 0;
                    cur_beats = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bit acc;
        int guard;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        acc   = 0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = s_axis_tready && !rst;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 200) begin
                chk("send_timeout", 0, 1);
                acc = 1;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_rv();
        int n;
        n = 0;
        while (!result_valid && n < 100) begin
            cyc();
            n++;
        end
        if (!result_valid) chk("result_valid_timeout", 0, 1);
    endtask

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][31:0] d;
        logic [31:0]      exp;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input logic [31:0] e);
        vec_t v;
        v.n   = 3'(n);
        v.d   = {d, c, b, a};
        v.exp = e;
        return v;
    endfunction

    task automatic run_random();
        bit   done_r;
        int   n;
        logic [31:0] d;
        done_r = 0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    n = $urandom_range(1, 20);
                    for (int b = 0; b < n; b++) begin
                        if ($urandom_range(0, 3) == 0) d = $urandom;
                        else d = $urandom_range(0, 1000);
                        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) cyc();
                        send(d, b == n - 1);
                    end
                end
                done_r = 1;
            end
            begin
                while (!done_r) begin
                    stall_i = ($urandom_range(0, 2) == 0);
                    cyc();
                end
                stall_i = 1'b0;
            end
        join
    endtask

    // ---------------- main sequence ----------------
    vec_t        tbl [7];
    logic [15:0] exp_cnt;
    int          a0;
    int          pulses;
    logic [31:0] got [2];

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        stall_i       = 1'b0;
        exp_cnt       = '0;

        tbl[0] = mk(4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10);
        tbl[1] = mk(2, 32'd5, 32'd5, 32'd0, 32'd0, 32'd10);
        tbl[2] = mk(1, 32'd7, 32'd0, 32'd0, 32'd0, 32'd7);
`ifdef AXIS_SUM_SAT_EN
        tbl[3] = mk(2, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 32'hFFFF_FFFF);
        tbl[5] = mk(3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF);
`else
        tbl[3] = mk(2, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 32'h0000_0010);
        tbl[5] = mk(3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h0000_0000);
`endif
        tbl[4] = mk(1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tbl[6] = mk(1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);

        // Values held during reset, then ready on the first edge after release.
        repeat (3) cyc();
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_err_len", err_len, 0);
        rst = 1'b0;
        cyc();
        chk("tready_after_rst", s_axis_tready, 1);

        // Table: each packet from idle, with exact latency and pulse width.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < int'(tbl[i].n); j++) begin
                send(tbl[i].d[j], j == int'(tbl[i].n) - 1);
            end
            chk("tbl_rv_n1", result_valid, 0);
            cyc();
            exp_cnt = exp_cnt + 16'd1;
            chk("tbl_rv_n2", result_valid, 1);
            chk("tbl_result", result, tbl[i].exp);
            chk("tbl_pkt_count", pkt_count, exp_cnt);
            cyc();
            chk("tbl_rv_width", result_valid, 0);
            chk("tbl_result_hold", result, tbl[i].exp);
            repeat (2) cyc();
        end

        // Back-to-back packets {5,5} then {7}.
        send(32'd5, 1'b0);
        send(32'd5, 1'b1);
        send(32'd7, 1'b1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (result_valid) begin
                if (pulses < 2) got[pulses] = result;
                pulses++;
            end
            cyc();
        end
        exp_cnt = exp_cnt + 16'd2;
        chk("b2b_pulses", 64'(pulses), 2);
        chk("b2b_first", got[0], 10);
        chk("b2b_second", got[1], 7);
        chk("b2b_pkt_count", pkt_count, exp_cnt);

        // Stall for 6 cycles while four beats are offered.
        stall_i = 1'b1;
        a0 = acc_cnt;
        fork
            begin
                send(32'd2, 1'b0);
                send(32'd4, 1'b0);
                send(32'd6, 1'b0);
                send(32'd8, 1'b1);
            end
            begin
                repeat (6) cyc();
                chk("stall_tready_low", s_axis_tready, 0);
                chk("stall_accepted", 64'(acc_cnt - a0), 2);
                stall_i = 1'b0;
            end
        join
        wait_rv();
        exp_cnt = exp_cnt + 16'd1;
        chk("stall_result", result, 20);
        chk("stall_pkt_count", pkt_count, exp_cnt);
        repeat (2) cyc();

        // Exactly MAX_BEATS beats: no length error.
        for (int b = 0; b < MAXB; b++) send(32'd1, b == MAXB - 1);
        wait_rv();
        chk("len16_result", result, 16);
        chk("len16_err", err_len, 0);
        repeat (2) cyc();

        // MAX_BEATS+1 beats: error, and the packet still ends at tlast.
        for (int b = 0; b < MAXB + 1; b++) send(32'd1, b == MAXB);
        wait_rv();
        chk("len17_result", result, 17);
        chk("len17_err", err_len, 1);
        repeat (2) cyc();
        send(32'd3, 1'b1);
        wait_rv();
        chk("err_sticky", err_len, 1);
        chk("after_err_result", result, 3);
        repeat (2) cyc();

        // Reset in the middle of a packet.
        send(32'd3, 1'b0);
        send(32'd9, 1'b0);
        rst = 1'b1;
        cyc();
        chk("midrst_result", result, 0);
        chk("midrst_rv", result_valid, 0);
        chk("midrst_pkt_count", pkt_count, 0);
        chk("midrst_err", err_len, 0);
        chk("midrst_tready", s_axis_tready, 0);
        rst = 1'b0;
        cyc();
        chk("midrst_tready_up", s_axis_tready, 1);
        send(32'd3, 1'b1);
        wait_rv();
        chk("midrst_new_result", result, 3);
        chk("midrst_new_count", pkt_count, 1);
        repeat (2) cyc();

        // Random traffic with random stalls. The monitor checks every pulse.
        run_random();
        for (int k = 0; k < 500 && (mdl_q.size() != 0 || cur_beats != 0); k++) cyc();
        repeat (4) cyc();
        chk("drain_pending", 64'(mdl_q.size()), 0);
        chk("drain_partial", 64'(cur_beats), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
